// File: rtl/slow_tick_counter.sv
// Two-digit BCD counter advanced by rising edges of a slow divided clock.
// A small IDLE/RUN/HOLD FSM gates counting; clear, load and increment are applied in that priority.
module slow_tick_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic       tick,
  output logic       wrap,
  output logic       load_err,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic       clk_div_q;
  logic       div_edge;
  logic       load_ok;
  logic [7:0] count_inc;
  logic [7:0] count_next;
  logic       wrap_next;
  logic       load_err_next;

  assign div_edge = clk_div & ~clk_div_q;
  assign load_ok  = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd9) && (load_val <= MAX_BCD);

  // clk_div_q resets high so a divider already high at reset release is not seen as an edge
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_div_q <= 1'b1;
      count_bcd <= 8'h00;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      clk_div_q <= clk_div;
      count_bcd <= count_next;
      tick      <= div_edge;
      wrap      <= wrap_next;
      load_err  <= load_err_next;
      running   <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (run)  state_next = RUN;
        RUN:     if (!run) state_next = HOLD;
        HOLD:    if (run)  state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_inc = count_bcd;
    if (count_bcd == MAX_BCD) begin
      count_inc = 8'h00;
    end else if (count_bcd[3:0] == 4'd9) begin
      count_inc = {count_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      count_inc = {count_bcd[7:4], count_bcd[3:0] + 4'd1};
    end
  end

  // A rejected load still blocks the increment for that cycle
  always_comb begin
    count_next    = count_bcd;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (clear) begin
      count_next = 8'h00;
    end else if (load) begin
      if (load_ok) begin
        count_next = load_val;
      end else begin
        load_err_next = 1'b1;
      end
    end else if ((state == RUN) && div_edge) begin
      count_next = count_inc;
      wrap_next  = (count_bcd == MAX_BCD);
    end
  end

endmodule

// File: tb/tb_slow_tick_counter.sv
// Directed bench for slow_tick_counter: stepping, BCD carry, wrap, hold,
// load rejection, clear precedence and asynchronous reset with clk_div high.
module tb_slow_tick_counter;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       clk_div;
  logic       run;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_bcd;
  logic       tick;
  logic       wrap;
  logic       load_err;
  logic       running;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_seen;

  slow_tick_counter #(.MAX_BCD(8'h59)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_div   (clk_div),
    .run       (run),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .count_bcd (count_bcd),
    .tick      (tick),
    .wrap      (wrap),
    .load_err  (load_err),
    .running   (running)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One 32-cycle divider period: 16 low, 16 high; checks the cycle after the rising edge
  task automatic div_period(input logic [7:0] exp_count, input logic exp_wrap);
    clk_div = 1'b0;
    repeat (16) @(negedge clk_in);
    clk_div = 1'b1;
    @(negedge clk_in);
    check_output("tick_hi", tick, 1'b1);
    check_output("count", count_bcd, exp_count);
    check_output("wrap", wrap, exp_wrap);
    @(negedge clk_in);
    check_output("tick_lo", tick, 1'b0);
    check_output("wrap_lo", wrap, 1'b0);
    repeat (14) @(negedge clk_in);
  endtask

  task automatic apply_stimulus(input logic [7:0] val);
    load_val = val;
    load     = 1'b1;
    @(negedge clk_in);
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_div = 1'b0; run = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'h00;
    repeat (2) @(negedge clk_in);
    check_output("rst_count", count_bcd, 8'h00);
    check_output("rst_tick", tick, 1'b0);
    check_output("rst_running", running, 1'b0);
    check_output("rst_load_err", load_err, 1'b0);
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk_in);
    check_output("running_on", running, 1'b1);

    for (int i = 1; i <= 7; i++) div_period(8'(i), 1'b0);

    // Hold at 07: ticks continue, count frozen
    run = 1'b0;
    @(negedge clk_in);
    check_output("hold_running", running, 1'b0);
    repeat (3) div_period(8'h07, 1'b0);
    run = 1'b1;
    @(negedge clk_in);
    check_output("resume_running", running, 1'b1);
    div_period(8'h08, 1'b0);
    div_period(8'h09, 1'b0);
    div_period(8'h10, 1'b0);

    apply_stimulus(8'h58);
    check_output("load58", count_bcd, 8'h58);
    check_output("load58_err", load_err, 1'b0);
    div_period(8'h59, 1'b0);
    div_period(8'h00, 1'b1);
    check_output("wrap_running", running, 1'b1);

    apply_stimulus(8'h5A);
    check_output("rej5A_err", load_err, 1'b1);
    check_output("rej5A_count", count_bcd, 8'h00);
    @(negedge clk_in);
    check_output("rej5A_err_lo", load_err, 1'b0);
    apply_stimulus(8'h60);
    check_output("rej60_err", load_err, 1'b1);
    check_output("rej60_count", count_bcd, 8'h00);
    @(negedge clk_in);
    check_output("rej60_err_lo", load_err, 1'b0);

    // Clear and load coinciding with a divider edge
    apply_stimulus(8'h25);
    check_output("load25", count_bcd, 8'h25);
    clk_div = 1'b0;
    repeat (16) @(negedge clk_in);
    clk_div = 1'b1; clear = 1'b1; load = 1'b1; load_val = 8'h30;
    @(negedge clk_in);
    clear = 1'b0; load = 1'b0;
    check_output("clr_count", count_bcd, 8'h00);
    check_output("clr_running", running, 1'b0);
    check_output("clr_wrap", wrap, 1'b0);
    check_output("clr_load_err", load_err, 1'b0);
    check_output("clr_tick", tick, 1'b1);
    @(negedge clk_in);
    check_output("clr_load_err2", load_err, 1'b0);
    repeat (14) @(negedge clk_in);

    // Async reset at 42 with clk_div held high
    apply_stimulus(8'h42);
    check_output("load42", count_bcd, 8'h42);
    #2 rst = 1'b1;
    #1;
    check_output("async_count", count_bcd, 8'h00);
    check_output("async_running", running, 1'b0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    tick_seen = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (tick) tick_seen++;
    end
    check_output("no_tick_after_rst", 8'(tick_seen), 8'h00);
    check_output("post_rst_count", count_bcd, 8'h00);
    check_output("post_rst_running", running, 1'b1);
    div_period(8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
